mmio_responder: RTL and testbench

Memory-mapped I/O responder on the CPU's data-memory bus: the device side of the KEY/SW/HEX/LEDR/LEDG address window the processor drives with loads and stores. It holds the HEX, LEDR and LEDG output registers and synchronizes and debounces the KEY and SW board inputs. It also latches sticky key-press event flags. It sits beside data memory in the top level; the CPU's load mux selects `rdata` when `hit` is asserted.

---
 rtl/mmio_pkg.sv | 41 ++++
 rtl/io_debouncer.sv | 51 +++++
 rtl/mmio_responder.sv | 109 ++++++++++
 tb/tb_mmio_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the board I/O responder: device addresses,
// board I/O widths and the seven-segment nibble encoder.
package mmio_pkg;

  localparam logic [31:0] MMIO_ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] MMIO_ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] MMIO_ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] MMIO_ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] MMIO_ADDR_SW   = 32'hF000_0014;

  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;
  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;
  localparam int HEX_W  = 16;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_debouncer.sv
// One board input bit: two-flop synchronizer followed by a stable-count debouncer.
// o_accept flags the edge at which o_db will take the synchronized value.
module io_debouncer
  import mmio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INIT            = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_sync,
  output logic o_db,
  output logic o_accept
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;

  assign w_differ = (r_s2 != r_db);
  assign o_accept = w_differ && (r_cnt == CNT_LAST);
  assign o_sync   = r_s2;
  assign o_db     = r_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1  <= INIT;
      r_s2  <= INIT;
      r_db  <= INIT;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Device side of the KEY/SW/HEX/LEDR/LEDG bus window: output registers,
// debounced board inputs, sticky key-press events and the load mux.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(MMIO_ADDR_HEX),
  parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(MMIO_ADDR_LEDR),
  parameter logic [DBITS-1:0] ADDR_LEDG       = DBITS'(MMIO_ADDR_LEDG),
  parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(MMIO_ADDR_KEY),
  parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(MMIO_ADDR_SW),
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  addr,
  input  logic [DBITS-1:0]  wdata,
  input  logic              we,
  input  logic              re,
  output logic [DBITS-1:0]  rdata,
  output logic              hit,
  input  logic [KEY_W-1:0]  KEY,
  input  logic [SW_W-1:0]   SW,
  output logic [LEDR_W-1:0] LEDR,
  output logic [LEDG_W-1:0] LEDG,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3
);

  logic [HEX_W-1:0]  r_hex;
  logic [LEDR_W-1:0] r_ledr;
  logic [LEDG_W-1:0] r_ledg;
  logic [KEY_W-1:0]  r_evt;

  logic w_sel_hex, w_sel_ledr, w_sel_ledg, w_sel_key, w_sel_sw;
  logic [KEY_W-1:0] w_key_sync, w_key_db_raw, w_key_acc, w_kdb, w_key_rise;
  logic [SW_W-1:0]  w_sw_sync, w_swdb, w_sw_acc;

  assign w_sel_hex  = (addr == ADDR_HEX);
  assign w_sel_ledr = (addr == ADDR_LEDR);
  assign w_sel_ledg = (addr == ADDR_LEDG);
  assign w_sel_key  = (addr == ADDR_KEY);
  assign w_sel_sw   = (addr == ADDR_SW);
  assign hit = w_sel_hex | w_sel_ledr | w_sel_ledg | w_sel_key | w_sel_sw;

  // Keys are debounced in the raw active-low domain (idle = 1) and inverted after.
  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    io_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_db (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (KEY[k]),
      .o_sync   (w_key_sync[k]),
      .o_db     (w_key_db_raw[k]),
      .o_accept (w_key_acc[k])
    );
  end

  for (genvar s = 0; s < SW_W; s++) begin : g_sw
    io_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)) u_db (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (SW[s]),
      .o_sync   (w_sw_sync[s]),
      .o_db     (w_swdb[s]),
      .o_accept (w_sw_acc[s])
    );
  end

  assign w_kdb      = ~w_key_db_raw;
  // A press is accepted when the debouncer commits a low raw level.
  assign w_key_rise = w_key_acc & ~w_key_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex  <= '0;
      r_ledr <= '0;
      r_ledg <= '0;
      r_evt  <= '0;
    end else begin
      if (we && w_sel_hex)  r_hex  <= wdata[HEX_W-1:0];
      if (we && w_sel_ledr) r_ledr <= wdata[LEDR_W-1:0];
      if (we && w_sel_ledg) r_ledg <= wdata[LEDG_W-1:0];
      // Set wins over a simultaneous write-1-to-clear.
      if (we && w_sel_key) r_evt <= (r_evt & ~wdata[KEY_W-1:0]) | w_key_rise;
      else                 r_evt <= r_evt | w_key_rise;
    end
  end

  assign LEDR = r_ledr;
  assign LEDG = r_ledg;
  assign HEX0 = hex7seg(r_hex[3:0]);
  assign HEX1 = hex7seg(r_hex[7:4]);
  assign HEX2 = hex7seg(r_hex[11:8]);
  assign HEX3 = hex7seg(r_hex[15:12]);

  always_comb begin
    rdata = '0;
    if (re) begin
      if (w_sel_hex)       rdata = DBITS'(r_hex);
      else if (w_sel_ledr) rdata = DBITS'(r_ledr);
      else if (w_sel_ledg) rdata = DBITS'(r_ledg);
      else if (w_sel_key)  rdata = DBITS'({r_evt, w_kdb});
      else if (w_sel_sw)   rdata = DBITS'(w_swdb);
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with a short debounce window; expected
// values are hand-computed constants.
module tb_mmio_responder;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;
  localparam logic [31:0] A_HOLE = 32'hF000_000C;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int total = 0;
  int bad   = 0;

  mmio_responder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .hit   (hit),
    .KEY   (KEY),
    .SW    (SW),
    .LEDR  (LEDR),
    .LEDG  (LEDG),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    tick();
    we = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0; re = 1'b1;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    KEY = 4'hF; SW = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // HEX register and encoder
    store(A_HEX, 32'h0000_A3F1);
    check("hex0_1", 32'(HEX0), 32'h79);
    check("hex1_f", 32'(HEX1), 32'h0E);
    check("hex2_3", 32'(HEX2), 32'h30);
    check("hex3_a", 32'(HEX3), 32'h08);
    load_chk("hex_rd", A_HEX, 32'h0000_A3F1);

    // Load in the same cycle as a store sees the old value
    addr = A_HEX; wdata = 32'h0000_1234; we = 1'b1; re = 1'b1;
    #1;
    check("hex_rd_old", rdata, 32'h0000_A3F1);
    tick();
    we = 1'b0;
    check("hex_rd_new", rdata, 32'h0000_1234);
    check("hex0_4", 32'(HEX0), 32'h19);

    // LEDs
    store(A_LEDR, 32'hFFFF_FFFF);
    check("ledr", 32'(LEDR), 32'h3FF);
    load_chk("ledr_rd", A_LEDR, 32'h3FF);
    store(A_LEDG, 32'h0000_01A5);
    check("ledg", 32'(LEDG), 32'hA5);
    load_chk("ledg_rd", A_LEDG, 32'hA5);
    load_chk("rd_re0_pre", A_LEDG, 32'hA5);
    re = 1'b0;
    #1;
    check("rd_re0", rdata, 32'h0);

    // Unmapped address
    addr = A_HOLE; wdata = 32'h0; we = 1'b1; re = 1'b1;
    #1;
    check("hole_hit", 32'(hit), 32'h0);
    check("hole_rd", rdata, 32'h0);
    tick();
    we = 1'b0;
    check("hole_ledr", 32'(LEDR), 32'h3FF);
    check("hole_ledg", 32'(LEDG), 32'hA5);
    check("hole_hex0", 32'(HEX0), 32'h19);
    addr = A_SW;
    #1;
    check("sw_hit", 32'(hit), 32'h1);

    // Switch debounce latency, then a short glitch
    SW = 10'h155;
    for (int i = 1; i <= 6; i++) begin
      tick();
      load_chk($sformatf("sw_lat%0d", i), A_SW, (i < 6) ? 32'h0 : 32'h155);
    end
    store(A_SW, 32'h0);
    load_chk("sw_wr_ign", A_SW, 32'h155);
    SW = 10'h157;
    tick(); tick(); tick();
    SW = 10'h155;
    for (int i = 0; i < 8; i++) tick();
    load_chk("sw_glitch", A_SW, 32'h155);

    // Reset asserted mid-debounce
    SW = 10'h2AA;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_hex0", 32'(HEX0), 32'h40);
    check("rst_hex1", 32'(HEX1), 32'h40);
    check("rst_hex2", 32'(HEX2), 32'h40);
    check("rst_hex3", 32'(HEX3), 32'h40);
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_ledg", 32'(LEDG), 32'h0);
    load_chk("rst_key", A_KEY, 32'h0);
    load_chk("rst_sw", A_SW, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      load_chk($sformatf("sw_rst_lat%0d", i), A_SW, (i < 6) ? 32'h0 : 32'h2AA);
    end

    // KEY[2] press, release, clear
    KEY = 4'hB;
    for (int i = 1; i <= 6; i++) begin
      tick();
      load_chk($sformatf("key_prs%0d", i), A_KEY, (i < 6) ? 32'h0 : 32'h44);
    end
    KEY = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      tick();
      load_chk($sformatf("key_rel%0d", i), A_KEY, (i < 6) ? 32'h44 : 32'h40);
    end
    store(A_KEY, 32'h4);
    load_chk("key_clr", A_KEY, 32'h0);

    // Press event coinciding with write-1-to-clear of the same bit
    KEY = 4'hE;
    for (int i = 0; i < 5; i++) tick();
    load_chk("key0_pre", A_KEY, 32'h0);
    store(A_KEY, 32'h1);
    load_chk("key0_setwins", A_KEY, 32'h11);
    store(A_KEY, 32'h1);
    load_chk("key0_clr", A_KEY, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
